vram_arb: RTL and testbench

//  Initiator side of the 64K x 16 VRAM port. Single VRAM port arbiter shared by video scan-out fetch and host register access.

---
 rtl/vram_arb.sv | 193 +++++++++++++++++++
 tb/tb_vram_arb.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arb.sv
// vram_arb: single-port VRAM arbiter (64K x 16) shared by video scan-out
// fetch and host register access.
//
// Video fetch has absolute priority and is never stalled. A host access is
// captured into a one-entry pending buffer on host_ack and issued on the
// first cycle without a video request. Read data returns the cycle after
// issue and is routed by a one-cycle return tag to the requester that
// issued the read.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   vid_sel, vid_addr                video read request (always granted)
//   vid_data, vid_valid              video read return, one cycle after vid_sel
//   host_req/wr/addr/wdata           host request, held until host_ack
//   host_ack                         request captured into the pending buffer
//   host_rdata, host_rvalid          host read return (rdata holds last value)
//   host_busy                        pending buffer full or host read in flight
//   host_starved                     sticky starvation flag, cleared by host_ack
//   vram_sel/wr_en/addr/wdata/rdata  VRAM port
module vram_arb #(
  parameter int unsigned STARVE_LIMIT = 255,
  parameter int unsigned WAIT_W       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        vid_sel,
  input  logic [15:0] vid_addr,
  output logic [15:0] vid_data,
  output logic        vid_valid,
  input  logic        host_req,
  input  logic        host_wr,
  input  logic [15:0] host_addr,
  input  logic [15:0] host_wdata,
  output logic        host_ack,
  output logic [15:0] host_rdata,
  output logic        host_rvalid,
  output logic        host_busy,
  output logic        host_starved,
  output logic        vram_sel,
  output logic        vram_wr_en,
  output logic [15:0] vram_addr,
  output logic [15:0] vram_wdata,
  input  logic [15:0] vram_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_PEND   = 2'b01,
    ST_RDWAIT = 2'b10
  } state_t;

  localparam logic [1:0]      TAG_NONE    = 2'b00;
  localparam logic [1:0]      TAG_VID     = 2'b01;
  localparam logic [1:0]      TAG_HOST    = 2'b10;
  localparam logic [WAIT_W:0] STARVE_LIM  = (WAIT_W + 1)'(STARVE_LIMIT);

  logic [1:0]        rst_sync_r;
  logic              rst_sync_n_s;
  state_t            state_r;
  logic              pend_wr_r;
  logic [15:0]       pend_addr_r;
  logic [15:0]       pend_wdata_r;
  logic [1:0]        tag_r;
  logic [WAIT_W-1:0] wait_cnt_r;
  logic              starved_r;
  logic [15:0]       host_rdata_r;

  logic              host_issue_s;
  logic              host_blocked_s;
  logic [WAIT_W:0]   wait_inc_s;
  logic              starve_hit_s;

  // Reset synchronizer: assertion propagates immediately, release is aligned to clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_r <= 2'b00;
    end else begin
      rst_sync_r <= {rst_sync_r[0], 1'b1};
    end
  end

  assign rst_sync_n_s = rst_sync_r[1];

  assign host_issue_s   = (state_r == ST_PEND) && !vid_sel;
  assign host_blocked_s = (state_r == ST_PEND) && vid_sel;
  assign wait_inc_s     = {1'b0, wait_cnt_r} + {{WAIT_W{1'b0}}, 1'b1};
  // Flag starvation during the blocked cycle that brings the wait to the limit.
  assign starve_hit_s   = host_blocked_s && (wait_inc_s >= STARVE_LIM);

  assign host_ack     = (state_r == ST_IDLE) && host_req;
  assign host_busy    = (state_r != ST_IDLE);
  assign host_starved = starved_r || starve_hit_s;
  assign vid_valid    = (tag_r == TAG_VID);
  assign vid_data     = vid_valid ? vram_rdata : 16'h0000;
  assign host_rvalid  = (tag_r == TAG_HOST);
  assign host_rdata   = host_rvalid ? vram_rdata : host_rdata_r;

  // VRAM port arbitration: video first, then the pending host access.
  always_comb begin
    vram_sel   = 1'b0;
    vram_wr_en = 1'b0;
    vram_addr  = 16'h0000;
    vram_wdata = pend_wdata_r;
    if (vid_sel) begin
      vram_sel  = 1'b1;
      vram_addr = vid_addr;
    end else if (host_issue_s) begin
      vram_sel   = 1'b1;
      vram_wr_en = pend_wr_r;
      vram_addr  = pend_addr_r;
    end else begin
      vram_sel   = 1'b0;
      vram_wr_en = 1'b0;
    end
  end

  // Host FSM, pending buffer and read-return tag.
  always_ff @(posedge clk or negedge rst_sync_n_s) begin
    if (!rst_sync_n_s) begin
      state_r      <= ST_IDLE;
      pend_wr_r    <= 1'b0;
      pend_addr_r  <= 16'h0000;
      pend_wdata_r <= 16'h0000;
      tag_r        <= TAG_NONE;
      host_rdata_r <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (host_req) begin
            pend_wr_r    <= host_wr;
            pend_addr_r  <= host_addr;
            pend_wdata_r <= host_wdata;
            state_r      <= ST_PEND;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_PEND: begin
          if (!vid_sel) begin
            state_r <= pend_wr_r ? ST_IDLE : ST_RDWAIT;
          end else begin
            state_r <= ST_PEND;
          end
        end
        ST_RDWAIT: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase

      if (vid_sel) begin
        tag_r <= TAG_VID;
      end else if (host_issue_s && !pend_wr_r) begin
        tag_r <= TAG_HOST;
      end else begin
        tag_r <= TAG_NONE;
      end

      if (host_rvalid) begin
        host_rdata_r <= vram_rdata;
      end else begin
        host_rdata_r <= host_rdata_r;
      end
    end
  end

  // Saturating host wait counter and sticky starvation flag.
  always_ff @(posedge clk or negedge rst_sync_n_s) begin
    if (!rst_sync_n_s) begin
      wait_cnt_r <= {WAIT_W{1'b0}};
      starved_r  <= 1'b0;
    end else begin
      if (host_ack) begin
        wait_cnt_r <= {WAIT_W{1'b0}};
      end else if (host_blocked_s && !(&wait_cnt_r)) begin
        wait_cnt_r <= wait_inc_s[WAIT_W-1:0];
      end else begin
        wait_cnt_r <= wait_cnt_r;
      end

      if (host_ack) begin
        starved_r <= 1'b0;
      end else if (starve_hit_s) begin
        starved_r <= 1'b1;
      end else begin
        starved_r <= starved_r;
      end
    end
  end

endmodule

// File: tb/tb_vram_arb.sv
// tb_vram_arb: directed self-checking bench for vram_arb (STARVE_LIMIT=4).
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge. A behavioural VRAM answers reads one cycle after issue;
// it is preloaded with addr ^ 16'h5A5A so expected read data is computable.
module tb_vram_arb;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        vid_sel;
  logic [15:0] vid_addr;
  logic [15:0] vid_data;
  logic        vid_valid;
  logic        host_req;
  logic        host_wr;
  logic [15:0] host_addr;
  logic [15:0] host_wdata;
  logic        host_ack;
  logic [15:0] host_rdata;
  logic        host_rvalid;
  logic        host_busy;
  logic        host_starved;
  logic        vram_sel;
  logic        vram_wr_en;
  logic [15:0] vram_addr;
  logic [15:0] vram_wdata;
  logic [15:0] vram_rdata;

  logic [15:0] mem [0:65535];
  int n_vec = 0;
  int n_err = 0;

  vram_arb #(.STARVE_LIMIT(4), .WAIT_W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .vid_sel(vid_sel), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_busy(host_busy), .host_starved(host_starved),
    .vram_sel(vram_sel), .vram_wr_en(vram_wr_en), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural synchronous VRAM.
  always @(posedge clk) begin
    if (vram_sel && vram_wr_en) mem[vram_addr] <= vram_wdata;
    vram_rdata <= (vram_sel && !vram_wr_en) ? mem[vram_addr] : 16'hDEAD;
  end

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [70:0] all_outs();
    return {vid_valid, host_ack, host_rvalid, host_busy, host_starved, vram_sel,
            vram_wr_en, vram_addr, vram_wdata, host_rdata, vid_data};
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; vid_sel = 1'b0; vid_addr = 16'h0000; host_req = 1'b0;
    host_wr = 1'b0; host_addr = 16'h0000; host_wdata = 16'h0000;
    step(); step();
    @(negedge clk);
    n_vec++; if (all_outs() !== 71'd0) begin n_err++; $display("FAIL reset_outs: got %h want 0", all_outs()); end
    step();
    reset_n = 1'b1;
    step(); step(); step();
    @(negedge clk);
    n_vec++; if (host_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", host_busy); end
    step();
  endtask

  task automatic test_host_write();
    host_req = 1'b1; host_wr = 1'b1; host_addr = 16'hABCD; host_wdata = 16'h1234;
    @(negedge clk);
    n_vec++; if ({host_ack, host_busy, vram_sel} !== 3'b100) begin n_err++; $display("FAIL wr_c0: ack/busy/sel got %b want 100", {host_ack, host_busy, vram_sel}); end
    step(); host_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({vram_sel, vram_wr_en, host_busy, host_ack} !== 4'b1110) begin n_err++; $display("FAIL wr_c1_ctl: got %b want 1110", {vram_sel, vram_wr_en, host_busy, host_ack}); end
    n_vec++; if ({vram_addr, vram_wdata} !== {16'hABCD, 16'h1234}) begin n_err++; $display("FAIL wr_c1_bus: got %h want abcd1234", {vram_addr, vram_wdata}); end
    step();
    @(negedge clk);
    n_vec++; if ({host_busy, vram_sel} !== 2'b00) begin n_err++; $display("FAIL wr_c2: busy/sel got %b want 00", {host_busy, vram_sel}); end
    step();
  endtask

  task automatic test_host_read();
    host_req = 1'b1; host_wr = 1'b0; host_addr = 16'hABCD;
    @(negedge clk);
    n_vec++; if (host_ack !== 1'b1) begin n_err++; $display("FAIL rd_ack: got %b want 1", host_ack); end
    step(); host_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({vram_sel, vram_wr_en, vram_addr, host_rvalid} !== {2'b10, 16'hABCD, 1'b0}) begin n_err++; $display("FAIL rd_issue: got %h want %h", {vram_sel, vram_wr_en, vram_addr, host_rvalid}, {2'b10, 16'hABCD, 1'b0}); end
    step();
    @(negedge clk);
    n_vec++; if ({host_rvalid, vid_valid, host_rdata} !== {2'b10, 16'h1234}) begin n_err++; $display("FAIL rd_return: got %h want %h", {host_rvalid, vid_valid, host_rdata}, {2'b10, 16'h1234}); end
    step();
    @(negedge clk);
    n_vec++; if ({host_rvalid, host_busy, host_rdata} !== {2'b00, 16'h1234}) begin n_err++; $display("FAIL rd_hold: got %h want %h", {host_rvalid, host_busy, host_rdata}, {2'b00, 16'h1234}); end
    step();
  endtask

  task automatic test_video_burst();
    int vv;
    vv = 0;
    vid_sel = 1'b1; vid_addr = 16'h0100; host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0010;
    @(negedge clk);
    n_vec++; if ({host_ack, vram_sel, vram_wr_en, vram_addr} !== {3'b110, 16'h0100}) begin n_err++; $display("FAIL vb_c0: got %h want %h", {host_ack, vram_sel, vram_wr_en, vram_addr}, {3'b110, 16'h0100}); end
    step(); host_req = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      vid_addr = 16'h0100 + 16'(i);
      @(negedge clk);
      if (vid_valid) vv++;
      n_vec++; if ({vram_addr, vram_wr_en, host_busy} !== {16'h0100 + 16'(i), 2'b01}) begin n_err++; $display("FAIL vb_arb%0d: got %h want %h", i, {vram_addr, vram_wr_en, host_busy}, {16'h0100 + 16'(i), 2'b01}); end
      n_vec++; if ({vid_valid, vid_data} !== {1'b1, pat(16'h0100 + 16'(i - 1))}) begin n_err++; $display("FAIL vb_data%0d: got %h want %h", i, {vid_valid, vid_data}, {1'b1, pat(16'h0100 + 16'(i - 1))}); end
      step();
    end
    vid_sel = 1'b0;
    @(negedge clk);
    if (vid_valid) vv++;
    n_vec++; if ({vid_valid, vid_data} !== {1'b1, pat(16'h0109)}) begin n_err++; $display("FAIL vb_last: got %h want %h", {vid_valid, vid_data}, {1'b1, pat(16'h0109)}); end
    n_vec++; if ({vram_sel, vram_wr_en, vram_addr} !== {2'b10, 16'h0010}) begin n_err++; $display("FAIL vb_host_issue: got %h want %h", {vram_sel, vram_wr_en, vram_addr}, {2'b10, 16'h0010}); end
    step();
    @(negedge clk);
    n_vec++; if ({host_rvalid, vid_valid, host_rdata} !== {2'b10, pat(16'h0010)}) begin n_err++; $display("FAIL vb_host_ret: got %h want %h", {host_rvalid, vid_valid, host_rdata}, {2'b10, pat(16'h0010)}); end
    n_vec++; if (host_starved !== 1'b1) begin n_err++; $display("FAIL vb_starved: got %b want 1", host_starved); end
    n_vec++; if (vv !== 10) begin n_err++; $display("FAIL vb_count: got %0d want 10", vv); end
    step();
  endtask

  task automatic test_starve();
    vid_sel = 1'b1; vid_addr = 16'h0180; host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0020;
    @(negedge clk);
    n_vec++; if (host_ack !== 1'b1) begin n_err++; $display("FAIL st_ack: got %b want 1", host_ack); end
    step(); host_req = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      vid_addr = 16'h0180 + 16'(k);
      @(negedge clk);
      n_vec++; if (host_starved !== (k >= 4)) begin n_err++; $display("FAIL st_blk%0d: got %b want %b", k, host_starved, (k >= 4)); end
      step();
    end
    vid_sel = 1'b0;
    @(negedge clk);
    n_vec++; if ({vram_sel, vram_addr, host_starved} !== {1'b1, 16'h0020, 1'b1}) begin n_err++; $display("FAIL st_issue: got %h want %h", {vram_sel, vram_addr, host_starved}, {1'b1, 16'h0020, 1'b1}); end
    step();
    @(negedge clk);
    n_vec++; if ({host_rvalid, host_rdata, host_starved} !== {1'b1, pat(16'h0020), 1'b1}) begin n_err++; $display("FAIL st_ret: got %h want %h", {host_rvalid, host_rdata, host_starved}, {1'b1, pat(16'h0020), 1'b1}); end
    step();
    host_req = 1'b1; host_addr = 16'h0021;
    @(negedge clk);
    n_vec++; if (host_ack !== 1'b1) begin n_err++; $display("FAIL st_ack2: got %b want 1", host_ack); end
    step(); host_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({host_starved, vram_sel, vram_addr} !== {2'b01, 16'h0021}) begin n_err++; $display("FAIL st_clear: got %h want %h", {host_starved, vram_sel, vram_addr}, {2'b01, 16'h0021}); end
    step();
    @(negedge clk);
    n_vec++; if ({host_rvalid, host_rdata} !== {1'b1, pat(16'h0021)}) begin n_err++; $display("FAIL st_ret2: got %h want %h", {host_rvalid, host_rdata}, {1'b1, pat(16'h0021)}); end
    step();
  endtask

  task automatic test_interleave();
    int rv;
    int vv;
    logic e_ack;
    rv = 0; vv = 0;
    for (int t = 0; t <= 19; t++) begin
      vid_sel   = (t % 2 == 0) && (t < 19);
      vid_addr  = 16'h0200 + 16'(t);
      host_req  = (t <= 15);
      host_wr   = 1'b0;
      host_addr = 16'h0300 + 16'((t + 1) / 4);
      e_ack     = (t <= 15) && ((t == 0) || (t % 4 == 3));
      @(negedge clk);
      if (host_rvalid) rv++;
      if (vid_valid) vv++;
      n_vec++; if (host_ack !== e_ack) begin n_err++; $display("FAIL il_ack t%0d: got %b want %b", t, host_ack, e_ack); end
      n_vec++; if (host_rvalid !== (t % 4 == 2)) begin n_err++; $display("FAIL il_rvalid t%0d: got %b want %b", t, host_rvalid, (t % 4 == 2)); end
      n_vec++; if (vid_valid !== (t % 2 == 1)) begin n_err++; $display("FAIL il_vvalid t%0d: got %b want %b", t, vid_valid, (t % 2 == 1)); end
      if (t % 4 == 2) begin
        n_vec++; if (host_rdata !== pat(16'h0300 + 16'(t / 4))) begin n_err++; $display("FAIL il_hdata t%0d: got %h want %h", t, host_rdata, pat(16'h0300 + 16'(t / 4))); end
      end
      if (t % 2 == 1) begin
        n_vec++; if (vid_data !== pat(16'h0200 + 16'(t - 1))) begin n_err++; $display("FAIL il_vdata t%0d: got %h want %h", t, vid_data, pat(16'h0200 + 16'(t - 1))); end
      end
      if (t % 4 == 1) begin
        n_vec++; if ({vram_sel, vram_wr_en, vram_addr} !== {2'b10, 16'h0300 + 16'(t / 4)}) begin n_err++; $display("FAIL il_hissue t%0d: got %h want %h", t, {vram_sel, vram_wr_en, vram_addr}, {2'b10, 16'h0300 + 16'(t / 4)}); end
      end else if (vid_sel) begin
        n_vec++; if (vram_addr !== 16'h0200 + 16'(t)) begin n_err++; $display("FAIL il_vissue t%0d: got %h want %h", t, vram_addr, 16'h0200 + 16'(t)); end
      end
      step();
    end
    vid_sel = 1'b0; host_req = 1'b0;
    n_vec++; if (rv !== 5) begin n_err++; $display("FAIL il_rcount: got %0d want 5", rv); end
    n_vec++; if (vv !== 10) begin n_err++; $display("FAIL il_vcount: got %0d want 10", vv); end
  endtask

  task automatic test_reset_mid();
    // Reset while the host read is pending behind video.
    host_req = 1'b1; host_wr = 1'b0; host_addr = 16'h0030; vid_sel = 1'b0;
    step(); host_req = 1'b0; vid_sel = 1'b1; vid_addr = 16'h0400;
    @(negedge clk);
    n_vec++; if (host_busy !== 1'b1) begin n_err++; $display("FAIL rm_pend: busy got %b want 1", host_busy); end
    step(); reset_n = 1'b0; vid_sel = 1'b0;
    #1;
    n_vec++; if (all_outs() !== 71'd0) begin n_err++; $display("FAIL rm_pend_outs: got %h want 0", all_outs()); end
    step(); step(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if ({host_rvalid, vram_sel, host_busy} !== 3'b000) begin n_err++; $display("FAIL rm_pend_after%0d: got %b want 000", i, {host_rvalid, vram_sel, host_busy}); end
      step();
    end
    // Reset during the read-return cycle.
    host_req = 1'b1; host_addr = 16'h0031;
    step(); host_req = 1'b0;
    step();
    reset_n = 1'b0;
    #1;
    n_vec++; if (all_outs() !== 71'd0) begin n_err++; $display("FAIL rm_rdw_outs: got %h want 0", all_outs()); end
    step(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++; if (host_rvalid !== 1'b0) begin n_err++; $display("FAIL rm_rdw_after%0d: got %b want 0", i, host_rvalid); end
      step();
    end
    // Normal operation resumes.
    host_req = 1'b1; host_wr = 1'b1; host_addr = 16'h0040; host_wdata = 16'h5555;
    @(negedge clk);
    n_vec++; if (host_ack !== 1'b1) begin n_err++; $display("FAIL rm_ack: got %b want 1", host_ack); end
    step(); host_req = 1'b0;
    @(negedge clk);
    n_vec++; if ({vram_sel, vram_wr_en, vram_addr, vram_wdata} !== {2'b11, 16'h0040, 16'h5555}) begin n_err++; $display("FAIL rm_write: got %h want %h", {vram_sel, vram_wr_en, vram_addr, vram_wdata}, {2'b11, 16'h0040, 16'h5555}); end
    step();
    host_req = 1'b1; host_wr = 1'b0;
    step(); host_req = 1'b0;
    step();
    @(negedge clk);
    n_vec++; if ({host_rvalid, host_rdata} !== {1'b1, 16'h5555}) begin n_err++; $display("FAIL rm_readback: got %h want %h", {host_rvalid, host_rdata}, {1'b1, 16'h5555}); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = pat(i[15:0]);
    test_reset();
    test_host_write();
    test_host_read();
    test_video_burst();
    test_starve();
    test_interleave();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
